// File: rtl/key_event_decoder.sv
// Key event classifier: turns debounced press/level activity into short, double,
// long and auto-repeat one-cycle event pulses.
module key_event_decoder #(
    parameter int LONG_CYC = 24_000_000,
    parameter int DBL_CYC  = 7_200_000,
    parameter int RPT_CYC  = 4_800_000,
    parameter int CNT_W    = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic key_flag,
    input  logic key_state,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic rpt_pulse,
    output logic busy
);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        PRESS1 = 5'b00010,
        WAIT2  = 5'b00100,
        PRESS2 = 5'b01000,
        LONG   = 5'b10000
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cnt_clr;
    logic             short_nxt, double_nxt, long_nxt, rpt_nxt;

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        short_nxt  = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        rpt_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (key_flag) state_nxt = PRESS1;
            end
            PRESS1: begin
                // Release wins over the long threshold in the same cycle
                if (!key_state) begin
                    state_nxt = WAIT2;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
                end
            end
            WAIT2: begin
                // A second press wins over the double-click timeout
                if (key_flag) begin
                    state_nxt  = PRESS2;
                    double_nxt = 1'b1;
                end else if (cnt == DBL_LAST) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                end
            end
            PRESS2: begin
                if (!key_state) state_nxt = IDLE;
            end
            LONG: begin
                if (!key_state) begin
                    state_nxt = IDLE;
                end else if (cnt == RPT_LAST) begin
                    rpt_nxt = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter restarts on every transition and on each repeat; it rests at zero in IDLE
    always_comb begin
        cnt_nxt = cnt;
        if ((state_nxt != state) || cnt_clr) begin
            cnt_nxt = '0;
        end else if (state != IDLE) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            short_pulse  <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            rpt_pulse    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            short_pulse  <= short_nxt;
            double_pulse <= double_nxt;
            long_pulse   <= long_nxt;
            rpt_pulse    <= rpt_nxt;
            busy         <= (state_nxt != IDLE);
        end
    end

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Classifies debounced key activity into short-press, double-click, long-press and auto-repeat events. It sits directly downstream of the key debouncer and consumes that stage's one-cycle `key_flag` press pulse and its `key_state` level. It emits one-cycle event pulses for the menu/control logic.

## Interface
- `LONG_CYC`, default 24_000_000: hold time in clocks, measured from press confirmation, that qualifies a long press (1 s at 24 MHz).
- `DBL_CYC`, default 7_200_000: window in clocks after the first release during which a second press makes a double-click (300 ms).
- `RPT_CYC`, default 4_800_000: auto-repeat period in clocks while a long press is held (200 ms).
- `CNT_W`, default 25: counter width; must hold max(LONG_CYC, DBL_CYC, RPT_CYC)-1.

Ports:
- `clk` in, 1 bit: single system clock; all logic is on the rising edge.
- `rst` in, 1 bit: asynchronous, active-high reset.
- `key_flag` in, 1 bit: one-cycle pulse from the debouncer when a press is confirmed; `key_state` is already 1 in that cycle.
- `key_state` in, 1 bit: debounced level; 1 = pressed, 0 = released.
- `short_pulse` out, 1 bit: one-cycle pulse for a single short press.
- `double_pulse` out, 1 bit: one-cycle pulse for a double-click.
- `long_pulse` out, 1 bit: one-cycle pulse when the long-press threshold is reached.
- `rpt_pulse` out, 1 bit: one-cycle pulse every RPT_CYC clocks while the long press is held.
- `busy` out, 1 bit: registered; high whenever the state is not IDLE.

## Operation
- One-hot FSM with states IDLE, PRESS1, WAIT2, PRESS2, LONG.
- A single counter `cnt` of width CNT_W is cleared on every state transition and increments by 1 in all other cycles outside IDLE.
- All outputs are registered. Pulses are asserted for exactly one cycle.

Transitions:
- **IDLE:** on `key_flag`=1, go to PRESS1. `key_state` is ignored in IDLE.
- **PRESS1:**
  - If `key_state`=0, go to WAIT2.
  - Else if `cnt`==LONG_CYC-1, go to LONG and assert `long_pulse`.
  - Release has priority when both conditions are true in the same cycle.
- **WAIT2:**
  - If `key_flag`=1, go to PRESS2 and assert `double_pulse`.
  - Else if `cnt`==DBL_CYC-1, go to IDLE and assert `short_pulse`.
  - `key_flag` has priority when both occur in the same cycle.
- **PRESS2:** if `key_state`=0, go to IDLE. No long or repeat detection in this state; holding the second press produces nothing further.
- **LONG:**
  - If `key_state`=0, go to IDLE with no pulse.
  - Else if `cnt`==RPT_CYC-1, assert `rpt_pulse` and clear `cnt`; stay in LONG.
  - Repeats continue indefinitely.
- `key_flag` in any state other than IDLE or WAIT2 is ignored.
- At most one of the four event pulses is high in any cycle.
- An illegal or unreachable state recovers to IDLE on the next clock, with all pulses 0.

## Timing
- **Reset:** asserting `rst` asynchronously forces state to IDLE, `cnt` to 0, and `short_pulse`, `double_pulse`, `long_pulse`, `rpt_pulse` and `busy` to 0. This applies mid-operation in any state. No pulse is emitted for a press that was in progress at reset.
- **Press entry:** `key_flag` sampled high at cycle t gives state PRESS1, `cnt`=0 and `busy`=1 at t+1.
- **Long:** with the key held throughout, `long_pulse`=1 at cycle t+LONG_CYC+1. The first `rpt_pulse` follows at t+LONG_CYC+RPT_CYC+1, then one every RPT_CYC cycles.
- **Release:** `key_state`=0 sampled at cycle r in PRESS1 gives WAIT2 at r+1. If no new press arrives, `short_pulse`=1 at r+DBL_CYC+1, and `busy` drops at the same cycle.
- **Double:** `key_flag` sampled at cycle s in WAIT2 gives `double_pulse`=1 at s+1.
- **Latency:** event pulses always appear one clock after the deciding sample. There is no handshake; consumers must sample every cycle.

## Test plan
All scenarios use LONG_CYC=20, DBL_CYC=8, RPT_CYC=5, with the `key_flag` pulse at cycle t.

1. **Short press:** key held 10 cycles, then `key_state`=0 first sampled at r=t+10. Expect `short_pulse` at r+9. No other pulses. `busy` high from t+1 through r+8.
2. **Long press with repeat:** key held 40 cycles. Expect `long_pulse` at t+21 and `rpt_pulse` at t+26, t+31, t+36. After release, nothing further and `busy`=0.
3. **Double-click:** short press, release at r, second `key_flag` at r+4. Expect `double_pulse` at r+5 and no `short_pulse` ever. Return to IDLE after the second release.
4. **Simultaneous events:**
   - Second `key_flag` exactly when WAIT2 `cnt`=7: expect `double_pulse` only.
   - Release exactly when PRESS1 `cnt`=19: expect WAIT2 and no `long_pulse`; `short_pulse` follows 9 cycles later.
5. **Reset mid-operation:** assert `rst` in LONG at t+28 for 3 cycles while the key stays held. Expect all outputs 0 immediately. After `rst` falls, no pulses until a new `key_flag`.
6. **Stray key_flag:** `key_flag` pulses while in PRESS1 or LONG. Expect no state change and timing identical to scenarios 1 and 2.
